// File: rtl/localizer_pkg.sv
// Shared widths, state encoding, saturation limits and sign/magnitude helper
// for the localizer divide sequencer.
package localizer_pkg;

  localparam int NUM_W = 223;
  localparam int DEN_W = 140;
  localparam int Q_W   = 91;
  localparam int MAG_W = Q_W - 1;
  localparam int HI_W  = NUM_W - MAG_W;
  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MAG_W - 1);
  localparam logic [Q_W-1:0]   Q_MAX    = {1'b0, {MAG_W{1'b1}}};
  localparam logic [Q_W-1:0]   Q_MIN    = {1'b1, {MAG_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    ITER_X,
    LOAD_Y,
    ITER_Y,
    DONE
  } state_t;

  typedef struct packed {
    logic             neg;
    logic [NUM_W-1:0] mag;
  } sm_t;

  // Magnitude is read as unsigned, so -2^(NUM_W-1) maps to 2^(NUM_W-1) exactly.
  function automatic sm_t sign_mag(input logic [NUM_W-1:0] v);
    sm_t r;
    r.neg = v[NUM_W-1];
    r.mag = r.neg ? -v : v;
    return r;
  endfunction

endpackage

// File: rtl/localizer_sdiv_step.sv
// One restoring divide step: shift in a dividend bit, trial-subtract the
// divisor, emit the quotient bit and the restored or reduced remainder.
module localizer_sdiv_step
  import localizer_pkg::*;
(
  input  logic [DEN_W:0]   rem_in,
  input  logic             bit_in,
  input  logic [DEN_W-1:0] dmag,
  output logic [DEN_W:0]   rem_out,
  output logic             q_bit
);

  logic [DEN_W:0] shifted;

  // A bit carried out of the shift means the partial remainder already exceeds dmag.
  always_comb begin
    shifted = {rem_in[DEN_W-1:0], bit_in};
    q_bit   = rem_in[DEN_W] || (shifted >= {1'b0, dmag});
    rem_out = q_bit ? (shifted - {1'b0, dmag}) : shifted;
  end

endmodule

// File: rtl/localizer_div_seq.sv
// Final divide stage of the TDOA localizer: one shared restoring divider computes
// posx then posy. Build option LOCALIZER_DIV_ROUND_EN: round half away from zero.
//
// state  | meaning
// IDLE   | waiting for an operand set
// LOAD_X | take |numx|, check zero denominator and x overflow
// ITER_X | 90 quotient bits of x, MSB first
// LOAD_Y | take |numy|, check y overflow
// ITER_Y | 90 quotient bits of y, MSB first
// DONE   | result held until out_ready
module localizer_div_seq
  import localizer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] numx,
  input  logic [NUM_W-1:0] numy,
  input  logic [DEN_W-1:0] denom,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   posx,
  output logic [Q_W-1:0]   posy,
  output logic             div_zero,
  output logic [1:0]       ovf,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [NUM_W-1:0] numx_r, numy_r;
  logic [DEN_W-1:0] den_r, dmag;
  logic [DEN_W:0]   rem_r, rem_nxt;
  logic [MAG_W-1:0] work_r;
  logic             neg_r;
  logic [CNT_W-1:0] cnt_r;
  sm_t              num_sm;
  logic             is_y, accept, den_zero, load_sat, load_neg, last;
  logic             q_bit, round_up;
  logic [Q_W-1:0]   q_full, q_signed;

  always_comb begin
    is_y     = (state == LOAD_Y) || (state == ITER_Y);
    num_sm   = sign_mag(is_y ? numy_r : numx_r);
    dmag     = den_r[DEN_W-1] ? -den_r : den_r;
    den_zero = (den_r == '0);
    // |num| >= |den|*2^90 exactly when |num| >> 90 >= |den|
    load_sat = {{(DEN_W-HI_W){1'b0}}, num_sm.mag[NUM_W-1:MAG_W]} >= dmag;
    load_neg = num_sm.neg ^ den_r[DEN_W-1];
    last     = (cnt_r == '0);
    accept   = in_valid && in_ready;
  end

  localizer_sdiv_step u_step (
    .rem_in  (rem_r),
    .bit_in  (work_r[MAG_W-1]),
    .dmag    (dmag),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
`ifdef LOCALIZER_DIV_ROUND_EN
    round_up = {rem_nxt, 1'b0} >= {2'b00, dmag};
`else
    round_up = 1'b0;
`endif
    q_full   = {1'b0, work_r[MAG_W-2:0], q_bit} + {{(Q_W-1){1'b0}}, round_up};
    q_signed = neg_r ? -q_full : q_full;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD_X;
      LOAD_X:  if (den_zero)      state_nxt = DONE;
               else if (load_sat) state_nxt = LOAD_Y;
               else               state_nxt = ITER_X;
      ITER_X:  if (last) state_nxt = LOAD_Y;
      LOAD_Y:  state_nxt = load_sat ? DONE : ITER_Y;
      ITER_Y:  if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      numx_r   <= '0;
      numy_r   <= '0;
      den_r    <= '0;
      rem_r    <= '0;
      work_r   <= '0;
      neg_r    <= 1'b0;
      cnt_r    <= '0;
      posx     <= '0;
      posy     <= '0;
      div_zero <= 1'b0;
      ovf      <= 2'b00;
    end else begin
      case (state)
        IDLE: if (accept) begin
          numx_r   <= numx;
          numy_r   <= numy;
          den_r    <= denom;
          div_zero <= 1'b0;
          ovf      <= 2'b00;
        end
        LOAD_X, LOAD_Y: begin
          if (den_zero) begin
            posx     <= '0;
            posy     <= '0;
            div_zero <= 1'b1;
          end else if (load_sat) begin
            if (is_y) posy <= load_neg ? Q_MIN : Q_MAX;
            else      posx <= load_neg ? Q_MIN : Q_MAX;
            ovf[is_y] <= 1'b1;
          end else begin
            rem_r  <= {{(DEN_W+1-HI_W){1'b0}}, num_sm.mag[NUM_W-1:MAG_W]};
            work_r <= num_sm.mag[MAG_W-1:0];
            neg_r  <= load_neg;
            cnt_r  <= CNT_INIT;
          end
        end
        ITER_X, ITER_Y: begin
          rem_r  <= rem_nxt;
          work_r <= {work_r[MAG_W-2:0], q_bit};
          cnt_r  <= cnt_r - 1'b1;
          if (last) begin
            // Only rounding can push the magnitude to 2^90.
            if (q_full[Q_W-1]) begin
              if (is_y) posy <= neg_r ? Q_MIN : Q_MAX;
              else      posx <= neg_r ? Q_MIN : Q_MAX;
              ovf[is_y] <= 1'b1;
            end else begin
              if (is_y) posy <= q_signed;
              else      posx <= q_signed;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/localizer_div_seq.md
# localizer_div_seq

Sequencer for the final divide stage of the TDOA localizer. It takes one numerator pair (numx, numy) and a shared denominator from the localizer arithmetic, then time-shares a single bit-serial restoring divider: first x, then y. It returns posx and posy through a valid/ready handshake. This replaces two wide combinational dividers with one small iterative unit, and flags degenerate geometry (denom = 0) and quotient overflow.

## Interface
- NUM_W, 223: signed numerator width.
- DEN_W, 140: signed denominator width.
- Q_W, 91: signed quotient width; magnitude range is Q_W-1 = 90 bits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block accepts operands; high only in IDLE.
- numx  in  NUM_W  signed x numerator.
- numy  in  NUM_W  signed y numerator.
- denom  in  DEN_W  signed shared denominator.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- posx  out  Q_W  signed x quotient.
- posy  out  Q_W  signed y quotient.
- div_zero  out  1  denom was 0 for this result.
- ovf  out  2  bit0: x saturated, bit1: y saturated.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, LOAD_X, ITER_X, LOAD_Y, ITER_Y, DONE.
- **IDLE**: in_valid && in_ready registers numx, numy and denom, then goes to LOAD_X. After acceptance the input buses are don't-care.
- **LOAD_X**:
  - Form |numx| and |denom|; record the sign as sign(numx) XOR sign(denom).
  - If denom == 0: posx = posy = 0, div_zero = 1, go to DONE.
  - Else if |numx| >= |denom|·2^90: saturate posx (positive → 2^90-1, negative → -2^90), set ovf[0], go to LOAD_Y.
  - Otherwise go to ITER_X.
- **ITER_X**: 90 restoring steps, MSB-first, one quotient bit per cycle. On the last step, apply the sign and write posx, then go to LOAD_Y.
- **LOAD_Y / ITER_Y**: same as the x path, using numy, ovf[1] and posy. Exit to DONE.
- **DONE**: out_valid = 1. posx, posy, div_zero and ovf hold stable until out_valid && out_ready, then return to IDLE.
- Arithmetic:
  - Default is truncation toward zero, matching Verilog signed `/`.
  - The remainder register is DEN_W+1 bits.
  - Magnitude of the most negative input is computed in the widened width.
- Flags div_zero and ovf clear on each acceptance.
- posx and posy keep their last value outside DONE and are overwritten per transaction.

## Timing
- Reset values: state IDLE, in_ready 0 while rst is high, out_valid 0, posx 0, posy 0, div_zero 0, ovf 0, busy 0.
- in_ready = (state == IDLE) && !rst. This is combinational from registered state only, with no in_valid → in_ready path.
- Normal latency: with the accept edge as edge 0, out_valid is high after edge 182 (2 load + 180 iteration edges).
- Zero denominator: out_valid is high after edge 1.
- Each saturated axis saves 90 cycles, so one saturated axis gives out_valid after edge 92.
- Output handshake edge in DONE → IDLE. A new acceptance can happen one cycle later at the earliest, so accept and release never occur in the same cycle.
- rst asserted in any state: at the next edge, go to IDLE, clear all outputs, and discard the in-flight operation.

## Configuration
- LOCALIZER_DIV_ROUND_EN defined:
  - After the final step, if 2·remainder >= |denom|, the magnitude is incremented (round half away from zero).
  - If the increment reaches 2^90, the result saturates and the matching ovf bit is set.
  - Latency is unchanged.
- Undefined: pure truncation toward zero.

## Structure
- localizer_pkg holds:
  - NUM_W, DEN_W and Q_W defaults.
  - The state enum.
  - Saturation constants Q_MAX = 2^90-1 and Q_MIN = -2^90.
  - A sign/magnitude helper function.
- Sub-module localizer_sdiv_step: one combinational restoring step (shift, trial subtract, quotient bit). It is instantiated once and shared between x and y by the FSM.

## Test plan
- numx=100, numy=-50, denom=10 → posx=10, posy=-5, div_zero=0, ovf=0, out_valid exactly 182 cycles after accept.
- numx=-7, numy=7, denom=2 → posx=-3, posy=3. With LOCALIZER_DIV_ROUND_EN: posx=-4, posy=4.
- denom=0, any numerators → out_valid after 1 cycle, posx=posy=0, div_zero=1.
- numx=2^100, numy=-2^100, denom=1 → posx=2^90-1, posy=-2^90, ovf=2'b11, out_valid after edge 2.
- Result held with out_ready low for 20 cycles → outputs stable and in_ready=0 throughout. Release → IDLE, and the next accept is no earlier than the following cycle.
- rst pulsed mid-ITER_Y → next cycle IDLE with all outputs 0. A fresh transaction (numx=9, numy=6, denom=3) then gives posx=3, posy=2.
